baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/uart_pkg.sv | 29 ++
 rtl/frac_div.sv | 81 ++++++++
 rtl/baud_gen_frac.sv | 176 +++++++++++++++++
 tb/tb_baud_gen_frac.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Constants and helpers shared by the UART family (baud_gen_frac, uart_tx,
//   uart_rx), so every block starts from the same baud configuration.
//
//   Contents
//     UART_DEF_DIV_INT    : integer divisor loaded at reset
//     UART_DEF_DIV_FRAC   : fractional divisor loaded at reset (2^-FRAC_W units)
//     UART_DEF_OVERSAMPLE : oversample ticks per baud period
//     UART_MIN_DIV        : smallest integer divisor the divider will run at
//     uart_oversample_ok  : legality test for an OVERSAMPLE value (even, >= 2)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DEF_DIV_INT    = 27;
    localparam int UART_DEF_DIV_FRAC   = 32;
    localparam int UART_DEF_OVERSAMPLE = 16;

    // A divisor of 1 would need tick_os on back-to-back cycles, so the divider
    // never runs faster than one tick every two cycles.
    localparam int UART_MIN_DIV        = 2;

    // baud_clk is built from two equal halves of the oversample count, which
    // only works for an even count of at least two.
    function automatic bit uart_oversample_ok(input int os);
        return (os >= 2) && ((os % 2) == 0);
    endfunction

endpackage

// File: rtl/frac_div.sv
// ---------------------------------------------------------------------------
// frac_div
//   Fractional-N cycle divider. A down-counter measures each oversample
//   period; at every reload a FRAC_W-bit phase accumulator adds the
//   fractional divisor, and its carry stretches the following period by one
//   cycle. Over 2^FRAC_W periods the average period is load_div + frac/2^FRAC_W.
//
//   Ports
//     sys_clk   : in  1       rising-edge clock
//     rst       : in  1       synchronous active-high reset
//     en        : in  1       run enable; low holds the divider idle
//     load_div  : in  DIV_W   integer divisor to reload with (already >= 2)
//     load_frac : in  FRAC_W  fractional divisor added at each reload
//     tick_next : out 1       combinational: this cycle is a reload, the
//                             registered tick_os rises on the coming edge
//     tick_os   : out 1       registered one-cycle oversample pulse
// ---------------------------------------------------------------------------
module frac_div #(
    parameter int               DIV_W   = 16,
    parameter int               FRAC_W  = 8,
    parameter logic [DIV_W-1:0] RST_CNT = DIV_W'(1)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  load_div,
    input  logic [FRAC_W-1:0] load_frac,
    output logic              tick_next,
    output logic              tick_os
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              tick_os_q, tick_os_d;
    logic [FRAC_W:0]   acc_sum;

    // Counter value 0 marks the last cycle of the current period.
    assign tick_next = en && (cnt_q == '0);

    // Extra top bit holds the carry out of the phase accumulator.
    assign acc_sum = {1'b0, acc_q} + {1'b0, load_frac};

    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        tick_os_d = 1'b0;

        if (!en) begin
            // Idle: preload a full unstretched period so the first tick after
            // enable lands exactly load_div cycles later.
            cnt_d = load_div - 1'b1;
            acc_d = '0;
        end else if (tick_next) begin
            tick_os_d = 1'b1;
            acc_d     = acc_sum[FRAC_W-1:0];
            // Loading load_div instead of load_div-1 adds the carry cycle.
            cnt_d     = acc_sum[FRAC_W] ? load_div : load_div - 1'b1;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments on every flop, so all registers
        // update together from values sampled before the edge.
        if (rst) begin
            cnt_q     <= RST_CNT;
            acc_q     <= '0;
            tick_os_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            tick_os_q <= tick_os_d;
        end
    end

    assign tick_os = tick_os_q;

endmodule

// File: rtl/baud_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_gen_frac
//   Fractional baud-rate generator. frac_div produces the oversample tick;
//   this level owns the shadow/active divisor configuration, the oversample
//   counter, tick_baud and the 50% duty baud_clk.
//
//   Configuration written while running goes to a shadow copy and becomes
//   active at the next reload, so a period is never cut or stretched
//   mid-flight. While idle the divider reloads every cycle, so writes (and
//   any shadow still waiting) take effect at once.
//
//   Ports
//     sys_clk     : in  1       rising-edge clock
//     rst         : in  1       synchronous active-high reset, highest priority
//     en          : in  1       run enable; low = idle, all outputs 0
//     cfg_load    : in  1       one-cycle strobe capturing div_int/div_frac
//     div_int     : in  DIV_W   integer cycles per oversample tick (<2 runs as 2)
//     div_frac    : in  FRAC_W  fractional cycles, units of 2^-FRAC_W
//     tick_os     : out 1       registered one-cycle oversample pulse
//     tick_baud   : out 1       registered pulse on every OVERSAMPLE-th tick_os
//     baud_clk    : out 1       registered 50% duty clock at the baud rate
//     cfg_pending : out 1       shadow configuration waiting for a reload
// ---------------------------------------------------------------------------
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 8,
    parameter int OVERSAMPLE   = UART_DEF_OVERSAMPLE,
    parameter int DEF_DIV_INT  = UART_DEF_DIV_INT,
    parameter int DEF_DIV_FRAC = UART_DEF_DIV_FRAC
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick_os,
    output logic              tick_baud,
    output logic              baud_clk,
    output logic              cfg_pending
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [OS_W-1:0]   OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0]  MIN_DIV      = DIV_W'(UART_MIN_DIV);
    localparam logic [DIV_W-1:0]  RST_DIV_INT  = DIV_W'(DEF_DIV_INT);
    localparam logic [FRAC_W-1:0] RST_DIV_FRAC = FRAC_W'(DEF_DIV_FRAC);
    localparam logic [DIV_W-1:0]  RST_DIV_EFF  =
        (RST_DIV_INT < MIN_DIV) ? MIN_DIV : RST_DIV_INT;

    if (!uart_oversample_ok(OVERSAMPLE)) begin : g_bad_oversample
        $error("baud_gen_frac: OVERSAMPLE must be even and >= 2");
    end

    // -----------------------------------------------------------------------
    // Configuration and baud state
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  shd_int_q,  shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              cfg_pending_q, cfg_pending_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              tick_baud_q, tick_baud_d;
    logic              baud_clk_q, baud_clk_d;

    logic [DIV_W-1:0]  sel_int;
    logic [FRAC_W-1:0] sel_frac;
    logic [DIV_W-1:0]  load_div;
    logic              tick_next;

    // Configuration that the next reload will use: a strobe in the reload
    // cycle itself wins, then a waiting shadow, then the running values.
    always_comb begin
        sel_int  = act_int_q;
        sel_frac = act_frac_q;
        if (cfg_load) begin
            sel_int  = div_int;
            sel_frac = div_frac;
        end else if (cfg_pending_q) begin
            sel_int  = shd_int_q;
            sel_frac = shd_frac_q;
        end
        load_div = (sel_int < MIN_DIV) ? MIN_DIV : sel_int;
    end

    // -----------------------------------------------------------------------
    // Oversample tick generation
    // -----------------------------------------------------------------------
    frac_div #(
        .DIV_W   (DIV_W),
        .FRAC_W  (FRAC_W),
        .RST_CNT (RST_DIV_EFF - 1'b1)
    ) u_frac_div (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .en        (en),
        .load_div  (load_div),
        .load_frac (sel_frac),
        .tick_next (tick_next),
        .tick_os   (tick_os)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        act_int_d     = act_int_q;
        act_frac_d    = act_frac_q;
        shd_int_d     = shd_int_q;
        shd_frac_d    = shd_frac_q;
        cfg_pending_d = cfg_pending_q;
        os_cnt_d      = os_cnt_q;
        tick_baud_d   = 1'b0;
        baud_clk_d    = baud_clk_q;

        if (cfg_load) begin
            shd_int_d  = div_int;
            shd_frac_d = div_frac;
        end

        if (!en) begin
            // The idle divider reloads every cycle, so configuration is
            // committed straight away and nothing is left pending.
            act_int_d     = sel_int;
            act_frac_d    = sel_frac;
            cfg_pending_d = 1'b0;
            os_cnt_d      = '0;
            baud_clk_d    = 1'b0;
        end else if (tick_next) begin
            act_int_d     = sel_int;
            act_frac_d    = sel_frac;
            cfg_pending_d = 1'b0;
            // Counter, tick_baud and baud_clk all move on the same edge that
            // raises tick_os, keeping the outputs aligned.
            os_cnt_d      = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
            tick_baud_d   = (os_cnt_q == OS_LAST);
            if ((os_cnt_q == OS_HALF) || (os_cnt_q == OS_LAST)) begin
                baud_clk_d = ~baud_clk_q;
            end
        end else if (cfg_load) begin
            cfg_pending_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            act_int_q     <= RST_DIV_INT;
            act_frac_q    <= RST_DIV_FRAC;
            shd_int_q     <= RST_DIV_INT;
            shd_frac_q    <= RST_DIV_FRAC;
            cfg_pending_q <= 1'b0;
            os_cnt_q      <= '0;
            tick_baud_q   <= 1'b0;
            baud_clk_q    <= 1'b0;
        end else begin
            act_int_q     <= act_int_d;
            act_frac_q    <= act_frac_d;
            shd_int_q     <= shd_int_d;
            shd_frac_q    <= shd_frac_d;
            cfg_pending_q <= cfg_pending_d;
            os_cnt_q      <= os_cnt_d;
            tick_baud_q   <= tick_baud_d;
            baud_clk_q    <= baud_clk_d;
        end
    end

    assign tick_baud   = tick_baud_q;
    assign baud_clk    = baud_clk_q;
    assign cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_frac
//   Self-checking bench for baud_gen_frac. A timestamp reference model
//   (absolute cycle of the next tick, phase accumulated as plain integers)
//   predicts every output each cycle; directed scenarios add closed-form
//   checks on tick spacing, baud_clk shape, config hand-over and reset.
// ---------------------------------------------------------------------------
module tb_baud_gen_frac;

    localparam int DIV_W    = 16;
    localparam int FRAC_W   = 8;
    localparam int OS       = 16;
    localparam int FRAC_MOD = 1 << FRAC_W;
    localparam int DEF_INT  = 27;
    localparam int DEF_FRAC = 32;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              tick_os;
    logic              tick_baud;
    logic              baud_clk;
    logic              cfg_pending;

    baud_gen_frac #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .OVERSAMPLE   (OS),
        .DEF_DIV_INT  (DEF_INT),
        .DEF_DIV_FRAC (DEF_FRAC)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .tick_os     (tick_os),
        .tick_baud   (tick_baud),
        .baud_clk    (baud_clk),
        .cfg_pending (cfg_pending)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int m_act_int, m_act_frac, m_shd_int, m_shd_frac;
    int m_acc, m_n, m_next;
    bit m_pend, m_run, m_tick;

    int cyc = 0;           // index of the next rising edge
    int start_edge = 0;    // edge that first sampled en=1
    int tlog[$];           // edges after which tick_os was seen high
    int blog[$];           // same for tick_baud
    int rise[$];
    int fall[$];
    bit prev_tick = 1'b0;
    bit prev_bclk = 1'b0;

    function automatic int clamp2(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_step(input int e);
        int ei, ef, carry;
        m_tick = 1'b0;
        if (rst) begin
            m_act_int = DEF_INT;  m_act_frac = DEF_FRAC;
            m_shd_int = DEF_INT;  m_shd_frac = DEF_FRAC;
            m_pend = 1'b0; m_run = 1'b0; m_n = 0;
        end else if (!en) begin
            if (cfg_load) begin
                m_act_int = int'(div_int);  m_act_frac = int'(div_frac);
                m_shd_int = int'(div_int);  m_shd_frac = int'(div_frac);
            end else if (m_pend) begin
                m_act_int = m_shd_int;  m_act_frac = m_shd_frac;
            end
            m_pend = 1'b0; m_run = 1'b0; m_n = 0;
        end else begin
            if (!m_run) begin
                m_run  = 1'b1;
                m_acc  = 0;
                m_n    = 0;
                m_next = e + clamp2(m_act_int) - 1;
            end
            if (e == m_next) begin
                if (cfg_load) begin
                    ei = int'(div_int);  ef = int'(div_frac);
                    m_shd_int = ei;  m_shd_frac = ef;
                end else if (m_pend) begin
                    ei = m_shd_int;  ef = m_shd_frac;
                end else begin
                    ei = m_act_int;  ef = m_act_frac;
                end
                m_act_int = ei;  m_act_frac = ef;  m_pend = 1'b0;
                m_acc  = m_acc + ef;
                carry  = (m_acc >= FRAC_MOD) ? 1 : 0;
                m_acc  = m_acc % FRAC_MOD;
                m_next = e + clamp2(ei) + carry;
                m_tick = 1'b1;
                m_n++;
            end else if (cfg_load) begin
                m_shd_int = int'(div_int);  m_shd_frac = int'(div_frac);
                m_pend = 1'b1;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT sampled on the falling edge.
    task automatic step();
        int e;
        @(posedge sys_clk);
        e = cyc;
        cyc++;
        model_step(e);
        @(negedge sys_clk);
        check("tick_os",     32'(tick_os),     32'(m_tick));
        check("tick_baud",   32'(tick_baud),   32'(m_tick && ((m_n % OS) == 0)));
        check("baud_clk",    32'(baud_clk),    32'(m_run && ((m_n % OS) >= OS / 2)));
        check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        check("tick_gap",    32'(tick_os & prev_tick), 32'(0));
        if (tick_os)   tlog.push_back(e);
        if (tick_baud) blog.push_back(e);
        if (baud_clk && !prev_bclk) rise.push_back(e);
        if (!baud_clk && prev_bclk) fall.push_back(e);
        prev_tick = tick_os;
        prev_bclk = baud_clk;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic idle_load(input int di, input int df);
        en       = 1'b0;
        cfg_load = 1'b1;
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        step();
        cfg_load = 1'b0;
        check("idle_load_no_pending", 32'(cfg_pending), 32'(0));
    endtask

    task automatic start_run();
        en = 1'b1;
        tlog.delete(); blog.delete(); rise.delete(); fall.delete();
        start_edge = cyc;
    endtask

    int bad;

    initial begin
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        div_int = '0; div_frac = '0;

        // Reset state
        run(3);
        check("rst_tick_os",     32'(tick_os),     32'(0));
        check("rst_tick_baud",   32'(tick_baud),   32'(0));
        check("rst_baud_clk",    32'(baud_clk),    32'(0));
        check("rst_cfg_pending", 32'(cfg_pending), 32'(0));
        rst = 1'b0;

        // div 27, frac 0: fixed 27-cycle ticks, 432-cycle baud
        idle_load(27, 0);
        start_run();
        run(900);
        check("int27_tick_count", tlog.size(), 33);
        if (tlog.size() >= 1) check("int27_first_tick", tlog[0] - start_edge + 1, 27);
        bad = 0;
        for (int k = 1; k < tlog.size(); k++) if (tlog[k] - tlog[k-1] != 27) bad++;
        check("int27_period_errors", bad, 0);
        check("int27_baud_count", blog.size(), 2);
        if (blog.size() >= 2) check("int27_baud_period", blog[1] - blog[0], 432);
        if (blog.size() >= 1 && tlog.size() >= 16) check("int27_baud_on_16th", blog[0], tlog[15]);
        check("int27_bclk_rises", rise.size(), 2);
        check("int27_bclk_falls", fall.size(), 2);
        if (rise.size() >= 2) check("int27_bclk_period", rise[1] - rise[0], 432);
        if (rise.size() >= 1 && fall.size() >= 1) check("int27_bclk_high", fall[0] - rise[0], 216);

        // div 27, frac 32: every 8th period stretched, first never stretched
        idle_load(27, 32);
        start_run();
        run(27 * 40 + 10);
        check("frac32_tick_count", tlog.size(), 40);
        for (int k = 1; k <= 40 && k <= tlog.size(); k++)
            check("frac32_tick_time", tlog[k-1] - start_edge + 1, 27 * k + ((k - 1) * 32) / 256);

        // div 27, frac 128: 256 periods span 27*256+128 cycles
        idle_load(27, 128);
        start_run();
        run(27 * 257 + 140);
        check("frac128_tick_count", tlog.size(), 257);
        if (tlog.size() >= 257) check("frac128_span", tlog[256] - tlog[0], 27 * 256 + 128);
        for (int k = 1; k <= 8 && k <= tlog.size(); k++)
            check("frac128_tick_time", tlog[k-1] - start_edge + 1, 27 * k + (k - 1) / 2);

        // div 1 runs as 2
        idle_load(1, 0);
        start_run();
        run(41);
        check("div1_tick_count", tlog.size(), 20);
        if (tlog.size() >= 1) check("div1_first_tick", tlog[0] - start_edge + 1, 2);
        bad = 0;
        for (int k = 1; k < tlog.size(); k++) if (tlog[k] - tlog[k-1] != 2) bad++;
        check("div1_period_errors", bad, 0);

        // Mid-period reconfiguration 27 -> 10
        idle_load(27, 0);
        start_run();
        run(40);
        cfg_load = 1'b1; div_int = DIV_W'(10); div_frac = '0;
        step();
        cfg_load = 1'b0;
        check("reconf_pending_set", 32'(cfg_pending), 32'(1));
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick_os) break;
            check("reconf_pending_hold", 32'(cfg_pending), 32'(1));
        end
        check("reconf_pending_clear", 32'(cfg_pending), 32'(0));
        run(25);
        check("reconf_tick_count", tlog.size(), 4);
        if (tlog.size() >= 4) begin
            check("reconf_old_period", tlog[1] - start_edge + 1, 54);
            check("reconf_new_period_a", tlog[2] - tlog[1], 10);
            check("reconf_new_period_b", tlog[3] - tlog[2], 10);
        end

        // en falls mid-period with baud_clk high (os count 10)
        idle_load(27, 0);
        start_run();
        for (int i = 0; i < 400 && tlog.size() < 10; i++) step();
        check("drop_reach_os10", tlog.size(), 10);
        run(3);
        check("drop_bclk_before", 32'(baud_clk), 32'(1));
        en = 1'b0;
        step();
        check("drop_tick_os",   32'(tick_os),   32'(0));
        check("drop_tick_baud", 32'(tick_baud), 32'(0));
        check("drop_baud_clk",  32'(baud_clk),  32'(0));

        // rst mid-period at os count 5 with a config pending
        start_run();
        for (int i = 0; i < 400 && tlog.size() < 5; i++) step();
        check("rst_reach_os5", tlog.size(), 5);
        run(3);
        cfg_load = 1'b1; div_int = DIV_W'(40); div_frac = '0;
        step();
        cfg_load = 1'b0;
        check("rst_pending_before", 32'(cfg_pending), 32'(1));
        rst = 1'b1;
        step();
        check("mid_rst_tick_os",     32'(tick_os),     32'(0));
        check("mid_rst_tick_baud",   32'(tick_baud),   32'(0));
        check("mid_rst_baud_clk",    32'(baud_clk),    32'(0));
        check("mid_rst_cfg_pending", 32'(cfg_pending), 32'(0));
        rst = 1'b0;
        start_run();
        run(27 * 9 + 5);
        check("post_rst_tick_count", tlog.size(), 9);
        for (int k = 1; k <= 9 && k <= tlog.size(); k++)
            check("post_rst_tick_time", tlog[k-1] - start_edge + 1, 27 * k + ((k - 1) * 32) / 256);

        // Randomised traffic against the model
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if (en) en = ($urandom_range(0, 299) != 0);
            else    en = ($urandom_range(0, 7) == 0);
            cfg_load = ($urandom_range(0, 39) == 0);
            div_int  = DIV_W'($urandom_range(0, 40));
            div_frac = FRAC_W'($urandom_range(0, 255));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
